mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter and sequencer that shares one single-port memory between the instruction-fetch stage (IF) and the data-memory stage (DM) of the pipeline. It accepts one request at a time and drives the shared memory port through a req/ack handshake. It returns fetched instructions or load data to the requester, and returns a completion pulse for stores. Arbitration gives DM strict priority, with an optional starvation guard for IF.

## Interface
Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- STARVE_LIMIT, 4, lost arbitrations IF tolerates before a forced IF grant (guard build only; legal range 1..15)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  one-cycle pulse: request captured
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DATA_W  fetched instruction
- dm_req  in  1  data request; held until dm_gnt
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_gnt  out  1  one-cycle pulse: request captured
- dm_done  out  1  one-cycle pulse: access complete (loads: dm_rdata valid)
- dm_rdata  out  DATA_W  load data
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  write enable to memory
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  memory completion; may assert in the same cycle mem_req rises
- mem_rdata  in  DATA_W  read data, valid when mem_ack = 1
- busy  out  1  state ≠ IDLE

## Operation
- FSM states:
  - IDLE
  - IF_ACC
  - DM_ACC
- IDLE, no requests: stay in IDLE.
- IDLE, dm_req only, or both requests with the guard not tripped: go to DM_ACC. Latch dm_we/dm_addr/dm_wdata onto mem_*. Set mem_req = 1. Pulse dm_gnt.
- IDLE, if_req only, or both requests with the guard tripped: go to IF_ACC. Latch if_addr; set mem_we = 0 and mem_req = 1. Pulse if_gnt.
- X_ACC with mem_ack = 1:
  - Next cycle: mem_req = 0, state = IDLE.
  - IF: if_rvalid = 1, if_rdata = mem_rdata.
  - DM: dm_done = 1; dm_rdata = mem_rdata on a load, dm_rdata unchanged on a store.
- X_ACC with mem_ack = 0: hold state and all mem_* outputs stable.
- mem_ack is ignored in IDLE.
- Request inputs are ignored outside IDLE. The requester keeps req high until its gnt pulse arrives.
- rdata outputs hold their last value between valid pulses.
- Reset values: every output 0, state IDLE, starvation counter 0.
- rst asserted mid-access:
  - Next cycle: IDLE with mem_req = 0.
  - No rvalid or done pulse is issued for the aborted access.
  - A late mem_ack is ignored.

## Timing
- Grant: request seen in IDLE at cycle N gives gnt pulse, mem_req = 1 and state X_ACC in cycle N+1.
- Completion: mem_ack sampled high at cycle M gives the rvalid/done pulse and IDLE in cycle M+1.
- Minimum access (ack in the same cycle as mem_req): req at N, rvalid/done at N+2.
- Back-to-back: the next grant is at N+3. Peak throughput is one access per 2 cycles plus memory wait cycles.
- Simultaneous if_req and dm_req in IDLE resolve in a single cycle. The loser keeps its request asserted and is re-arbitrated on the next return to IDLE.
- No combinational path from any input to any output. All outputs are registered.

## Configuration
- Macro: MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - A 4-bit counter increments each time DM wins while if_req = 1.
  - When the counter equals STARVE_LIMIT, the next IDLE decision with if_req = 1 grants IF, even if dm_req = 1.
  - Any IF grant clears the counter.
- Undefined:
  - Strict DM priority; no counter is built.
  - IF can starve indefinitely under continuous dm_req.

## Test plan
- Single fetch: if_req = 1, if_addr = 0x10 at N; mem_ack = 1, mem_rdata = 0xDEADBEEF at N+1 → if_gnt at N+1, if_rvalid = 1 with if_rdata = 0xDEADBEEF at N+2, busy low at N+2.
- Store with 3 wait cycles: dm_req = 1, dm_we = 1, dm_addr = 0x20, dm_wdata = 0x5A at N; mem_ack at N+4 → mem_req = 1, mem_we = 1, mem_addr = 0x20, mem_wdata = 0x5A held N+1..N+4; dm_done at N+5; dm_rdata unchanged.
- Collision: if_req and dm_req both 1 at N → dm_gnt at N+1; after ack at N+1, if_gnt at N+3.
- Starvation, STARVE_LIMIT = 4, guard built: dm_req and if_req held high, mem_ack tied high → 4 DM grants, then 1 IF grant, then the pattern repeats. Without the macro: DM grants only.
- Reset mid-access: rst at N+2 while in DM_ACC with mem_ack = 0; mem_ack pulsed at N+4 → at N+3 all outputs 0 and state IDLE; no dm_done pulse.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch (IF) and data memory (DM).
//   DM has strict priority. Define MEM_ARB_STARVE_GUARD_EN to build a starvation guard that forces
//   an IF grant after STARVE_LIMIT consecutive DM wins against a pending fetch.
//   Ports: clk/rst (sync, active-high); IF side if_req/if_addr -> if_gnt/if_rvalid/if_rdata;
//   DM side dm_req/dm_we/dm_addr/dm_wdata -> dm_gnt/dm_done/dm_rdata;
//   memory side mem_req/mem_we/mem_addr/mem_wdata <- mem_ack/mem_rdata; busy = not idle.
//   Every output is driven straight from a register.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC} state_t;
    state_t            state_q, state_d;
    logic              if_gnt_q, if_gnt_d, if_rvalid_q, if_rvalid_d;
    logic              dm_gnt_q, dm_gnt_d, dm_done_q, dm_done_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              trip, grant_if, grant_dm, idle;
    assign idle     = (state_q == IDLE);
    assign grant_if = idle && if_req && (!dm_req || trip);
    assign grant_dm = idle && dm_req && !grant_if;
`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [3:0] starve_q, starve_d;
    assign trip = (starve_q == 4'(STARVE_LIMIT));
    always_comb begin
        starve_d = starve_q;
        if (grant_if) starve_d = 4'd0;
        else if (grant_dm && if_req) starve_d = starve_q + 4'd1;
    end
    always_ff @(posedge clk) starve_q <= rst ? 4'd0 : starve_d;
`else
    // No guard: IF only wins when DM is silent (limit referenced only to keep it used).
    assign trip = 1'b0 && (STARVE_LIMIT > 0);
`endif
    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            if_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_gnt_q    <= 1'b0;
            dm_done_q   <= 1'b0;
            dm_rdata_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            if_gnt_q    <= if_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            dm_gnt_q    <= dm_gnt_d;
            dm_done_q   <= dm_done_d;
            dm_rdata_q  <= dm_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end
    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (idle) state_d = grant_dm ? DM_ACC : grant_if ? IF_ACC : IDLE;
        else if (mem_ack) state_d = IDLE;
    end
    // Output next-values: mem_* hold while an access is outstanding
    always_comb begin
        if_gnt_d    = grant_if;
        dm_gnt_d    = grant_dm;
        if_rvalid_d = (state_q == IF_ACC) && mem_ack;
        dm_done_d   = (state_q == DM_ACC) && mem_ack;
        if_rdata_d  = if_rvalid_d ? mem_rdata : if_rdata_q;
        // mem_we_q still holds the captured direction, so a store leaves dm_rdata untouched
        dm_rdata_d  = (dm_done_d && !mem_we_q) ? mem_rdata : dm_rdata_q;
        mem_req_d   = idle ? (grant_if || grant_dm) : !mem_ack;
        mem_we_d    = grant_dm ? dm_we : grant_if ? 1'b0 : mem_we_q;
        mem_addr_d  = grant_dm ? dm_addr : grant_if ? if_addr : mem_addr_q;
        mem_wdata_d = grant_dm ? dm_wdata : mem_wdata_q;
    end
    assign if_gnt    = if_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_gnt    = dm_gnt_q;
    assign dm_done   = dm_done_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = !idle;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table plus grant-order scoreboard for mem_port_arbiter.
module tb_mem_port_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ack = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
    logic        if_gnt, if_rvalid, dm_gnt, dm_done, mem_req, mem_we, busy;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    int          tests = 0, fails = 0;

    typedef struct packed {
        logic rst; logic ifr; logic [31:0] ifa; logic dmr; logic we;
        logic [31:0] dma; logic [31:0] wd; logic ack; logic [31:0] rd;
    } in_t;
    typedef struct packed {
        logic ig; logic iv; logic [31:0] ird; logic dg; logic dd; logic [31:0] drd;
        logic mr; logic mw; logic [31:0] ma; logic [31:0] mwd; logic b;
    } out_t;
    typedef struct packed { in_t i; out_t o; } vec_t;

    vec_t vt[$];
    out_t exp_q[$];
    logic gq[$];

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_done(dm_done), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic in_t mk_in(logic r, logic ifr, logic [31:0] ifa, logic dmr, logic we,
                                  logic [31:0] dma, logic [31:0] wd, logic ack, logic [31:0] rd);
        return '{r, ifr, ifa, dmr, we, dma, wd, ack, rd};
    endfunction

    function automatic out_t mk_out(logic ig, logic iv, logic [31:0] ird, logic dg, logic dd,
                                    logic [31:0] drd, logic mr, logic mw, logic [31:0] ma,
                                    logic [31:0] mwd, logic b);
        return '{ig, iv, ird, dg, dd, drd, mr, mw, ma, mwd, b};
    endfunction

    task automatic drive(input in_t v);
        rst = v.rst; if_req = v.ifr; if_addr = v.ifa; dm_req = v.dmr; dm_we = v.we;
        dm_addr = v.dma; dm_wdata = v.wd; mem_ack = v.ack; mem_rdata = v.rd;
    endtask

    initial begin
        out_t act, exp;
        logic exp_if;
        int   seen;
        // Each row: inputs in cycle k, outputs expected in cycle k+1.
        vt.push_back('{mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0),
                       mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        // single fetch, ack in same cycle as mem_req
        vt.push_back('{mk_in(0, 1, 32'h10, 0, 0, 0, 0, 0, 0),
                       mk_out(1, 0, 0, 0, 0, 0, 1, 0, 32'h10, 0, 1)});
        vt.push_back('{mk_in(0, 1, 32'h10, 0, 0, 0, 0, 1, 32'hDEADBEEF),
                       mk_out(0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 32'h10, 0, 0)});
        // store with three wait cycles
        vt.push_back('{mk_in(0, 0, 0, 1, 1, 32'h20, 32'h5A, 0, 0),
                       mk_out(0, 0, 32'hDEADBEEF, 1, 0, 0, 1, 1, 32'h20, 32'h5A, 1)});
        for (int k = 0; k < 3; k++)
            vt.push_back('{mk_in(0, 0, 0, k == 0, k == 0, 32'h20, 32'h5A, 0, 32'hBAD),
                           mk_out(0, 0, 32'hDEADBEEF, 0, 0, 0, 1, 1, 32'h20, 32'h5A, 1)});
        vt.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 1, 32'h1234),
                       mk_out(0, 0, 32'hDEADBEEF, 0, 1, 0, 0, 1, 32'h20, 32'h5A, 0)});
        // load
        vt.push_back('{mk_in(0, 0, 0, 1, 0, 32'h30, 32'h77, 0, 0),
                       mk_out(0, 0, 32'hDEADBEEF, 1, 0, 0, 1, 0, 32'h30, 32'h77, 1)});
        vt.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D),
                       mk_out(0, 0, 32'hDEADBEEF, 0, 1, 32'hCAFEF00D, 0, 0, 32'h30, 32'h77, 0)});
        // ack in IDLE is ignored
        vt.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 1, 32'h99999999),
                       mk_out(0, 0, 32'hDEADBEEF, 0, 0, 32'hCAFEF00D, 0, 0, 32'h30, 32'h77, 0)});
        // collision: DM first, IF granted at N+3
        vt.push_back('{mk_in(0, 1, 32'h44, 1, 0, 32'h50, 0, 0, 0),
                       mk_out(0, 0, 32'hDEADBEEF, 1, 0, 32'hCAFEF00D, 1, 0, 32'h50, 0, 1)});
        vt.push_back('{mk_in(0, 1, 32'h44, 0, 0, 0, 0, 1, 32'h11),
                       mk_out(0, 0, 32'hDEADBEEF, 0, 1, 32'h11, 0, 0, 32'h50, 0, 0)});
        vt.push_back('{mk_in(0, 1, 32'h44, 0, 0, 0, 0, 0, 0),
                       mk_out(1, 0, 32'hDEADBEEF, 0, 0, 32'h11, 1, 0, 32'h44, 0, 1)});
        vt.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 1, 32'h22),
                       mk_out(0, 1, 32'h22, 0, 0, 32'h11, 0, 0, 32'h44, 0, 0)});
        // reset mid-access, then a late ack
        vt.push_back('{mk_in(0, 0, 0, 1, 1, 32'h60, 32'hAB, 0, 0),
                       mk_out(0, 0, 32'h22, 1, 0, 32'h11, 1, 1, 32'h60, 32'hAB, 1)});
        vt.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0),
                       mk_out(0, 0, 32'h22, 0, 0, 32'h11, 1, 1, 32'h60, 32'hAB, 1)});
        vt.push_back('{mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0),
                       mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        vt.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 1, 32'h33),
                       mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});

        for (int n = 0; n < vt.size(); n++) begin
            drive(vt[n].i);
            exp_q.push_back(vt[n].o);
            @(posedge clk);
            #1;
            act = '{if_gnt, if_rvalid, if_rdata, dm_gnt, dm_done, dm_rdata,
                    mem_req, mem_we, mem_addr, mem_wdata, busy};
            exp = exp_q.pop_front();
            tests++;
            if (act !== exp) begin
                fails++;
                $display("FAIL vec%0d: got %h expected %h", n, act, exp);
            end
        end

        // starvation: both requests held, memory always acks immediately
        for (int k = 0; k < 10; k++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            gq.push_back((k % 5) == 4);
`else
            gq.push_back(1'b0);
`endif
        end
        drive(mk_in(0, 1, 32'h100, 1, 0, 32'h200, 0, 1, 32'h5));
        seen = 0;
        for (int c = 0; c < 60 && gq.size() > 0; c++) begin
            @(posedge clk);
            #1;
            if (if_gnt || dm_gnt) begin
                exp_if = gq.pop_front();
                tests++;
                if ((if_gnt && dm_gnt) || (if_gnt !== exp_if)) begin
                    fails++;
                    $display("FAIL starve_grant%0d: if_gnt=%b dm_gnt=%b expected if_gnt=%b",
                             seen, if_gnt, dm_gnt, exp_if);
                end
                seen++;
            end
        end
        tests++;
        if (gq.size() != 0) begin
            fails++;
            $display("FAIL starve_timeout: %0d grants pending, expected 0", gq.size());
        end
        drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
